// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared constants, frame-width macro and receiver state encoding for the sound block
`ifndef SND_PKG_DEFS
`define SND_PKG_DEFS
`define SND_FRAME_W(sw) (2*(sw))
`endif

package snd_pkg;

    localparam int   SND_SAMPLE_W = 16;
    localparam logic SND_LR_LEFT  = 1'b0;
    localparam logic SND_LR_RIGHT = 1'b1;

    typedef enum logic {
        RX_UNSYNC = 1'b0,
        RX_SYNC   = 1'b1
    } rx_state_t;

endpackage

// File: rtl/snd_rx_fifo.sv
// rtl/snd_rx_fifo.sv - synchronous first-word-fall-through frame FIFO
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module snd_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/snd_i2s_rx.sv
// rtl/snd_i2s_rx.sv - I2S slave receiver: oversampled deserialiser feeding a stereo frame FIFO
// Optional SND_RX_DROPCNT_EN adds a saturating dropped-frame counter output RX_DROPCNT.
module snd_i2s_rx
    import snd_pkg::*;
#(
    parameter int SAMPLE_W   = SND_SAMPLE_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic                               RX_EN,
    input  logic                               SND_BCLK,
    input  logic                               SND_LRCLK,
    input  logic                               SND_DIN,
    output logic [`SND_FRAME_W(SAMPLE_W)-1:0]  RX_DATA,
    output logic                               RX_VALID,
    input  logic                               RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]        RX_LEVEL,
    input  logic                               OVER_CLR,
    output logic                               SND_FIFO_OVER
`ifdef SND_RX_DROPCNT_EN
    ,
    output logic [15:0]                        RX_DROPCNT
`endif
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] LP_FULL_CNT = CNT_W'(SAMPLE_W);

    // Bits [1:0] are the synchroniser; bclk bit [2] is the previous value for edge detection.
    logic [2:0]          r_bclk_sync;
    logic [1:0]          r_lr_sync;
    logic [1:0]          r_din_sync;

    rx_state_t           r_state;
    logic                r_lr_d;
    logic                r_lr_dd;
    logic                r_left_ok;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_shreg;
    logic [SAMPLE_W-1:0] r_left;
    logic                r_over;

    logic                w_rise;
    logic                w_din;
    logic                w_lr;
    logic                w_word_start;
    logic                w_shift;
    logic [SAMPLE_W-1:0] w_shreg_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_word_done;
    logic                w_active;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_din_sync  <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], SND_BCLK};
            r_lr_sync   <= {r_lr_sync[0], SND_LRCLK};
            r_din_sync  <= {r_din_sync[0], SND_DIN};
        end
    end

    assign w_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_din  = r_din_sync[1];
    assign w_lr   = r_lr_sync[1];

    // r_lr_d is the channel that owns the bit sampled now (one-bit I2S delay).
    assign w_word_start = (r_lr_d != r_lr_dd);
    assign w_shift      = !w_word_start && (r_cnt < LP_FULL_CNT);
    assign w_shreg_next = w_word_start ? {{(SAMPLE_W-1){1'b0}}, w_din}
                                       : {r_shreg[SAMPLE_W-2:0], w_din};
    assign w_cnt_next   = w_word_start ? CNT_W'(1) : r_cnt + 1'b1;
    assign w_word_done  = (w_word_start || w_shift) && (w_cnt_next == LP_FULL_CNT);
    assign w_active     = (r_state == RX_SYNC) || (w_word_start && (r_lr_d == SND_LR_LEFT));
    assign w_push       = RX_EN && w_rise && w_active && w_word_done
                          && (r_lr_d == SND_LR_RIGHT) && r_left_ok;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= RX_UNSYNC;
            r_lr_d    <= 1'b0;
            r_lr_dd   <= 1'b0;
            r_left_ok <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_left    <= '0;
        end else begin
            if (w_rise) begin
                r_lr_dd <= r_lr_d;
                r_lr_d  <= w_lr;
            end
            if (!RX_EN) begin
                r_state   <= RX_UNSYNC;
                r_cnt     <= '0;
                r_left_ok <= 1'b0;
            end else if (w_rise && w_active) begin
                r_state <= RX_SYNC;
                if (w_word_start || w_shift) begin
                    r_shreg <= w_shreg_next;
                    r_cnt   <= w_cnt_next;
                end
                // A channel change before the word filled means the previous slot was short.
                if (w_word_start && (r_cnt != LP_FULL_CNT)) begin
                    r_left_ok <= 1'b0;
                end
                if (w_word_done) begin
                    if (r_lr_d == SND_LR_LEFT) begin
                        r_left    <= w_shreg_next;
                        r_left_ok <= 1'b1;
                    end else begin
                        r_left_ok <= 1'b0;
                    end
                end
            end
        end
    end

    assign RX_VALID = !w_empty;
    assign w_pop    = RX_VALID && RX_READY;
    assign w_drop   = w_push && w_full && !w_pop;

    snd_rx_fifo #(
        .WIDTH (`SND_FRAME_W(SAMPLE_W)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_push  (w_push),
        .i_data  ({r_left, w_shreg_next}),
        .i_pop   (w_pop),
        .o_data  (RX_DATA),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (RX_LEVEL)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_over <= 1'b0;
        end else if (w_drop) begin
            r_over <= 1'b1;
        end else if (OVER_CLR) begin
            r_over <= 1'b0;
        end
    end

    assign SND_FIFO_OVER = r_over;

`ifdef SND_RX_DROPCNT_EN
    logic [15:0] r_dropcnt;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_dropcnt <= '0;
        end else if (OVER_CLR) begin
            r_dropcnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_dropcnt != 16'hFFFF)) begin
            r_dropcnt <= r_dropcnt + 16'd1;
        end
    end

    assign RX_DROPCNT = r_dropcnt;
`endif

endmodule

// File: tb/tb_snd_i2s_rx.sv
// tb/tb_snd_i2s_rx.sv - directed self-checking bench for snd_i2s_rx (BCLK = ACLK/8, I2S framing)
module tb_snd_i2s_rx;

    logic        ACLK      = 1'b0;
    logic        ARESET    = 1'b1;
    logic        RX_EN     = 1'b0;
    logic        SND_BCLK  = 1'b1;
    logic        SND_LRCLK = 1'b1;
    logic        SND_DIN   = 1'b0;
    logic        RX_READY  = 1'b0;
    logic        OVER_CLR  = 1'b0;
    logic [31:0] RX_DATA;
    logic        RX_VALID;
    logic [4:0]  RX_LEVEL;
    logic        SND_FIFO_OVER;
`ifdef SND_RX_DROPCNT_EN
    logic [15:0] RX_DROPCNT;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    logic tb_prev_din = 1'b0;

    snd_i2s_rx #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .RX_EN         (RX_EN),
        .SND_BCLK      (SND_BCLK),
        .SND_LRCLK     (SND_LRCLK),
        .SND_DIN       (SND_DIN),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_READY      (RX_READY),
        .RX_LEVEL      (RX_LEVEL),
        .OVER_CLR      (OVER_CLR),
        .SND_FIFO_OVER (SND_FIFO_OVER)
`ifdef SND_RX_DROPCNT_EN
        ,
        .RX_DROPCNT    (RX_DROPCNT)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Data lags LRCLK by one bit: the bit handed in here goes out on the next call.
    // mode 0: check push-to-valid timing of frame 1234ABCD; mode 1: pop exactly on the push cycle.
    task automatic send_bit(input logic lr, input logic d, input int mode);
        SND_BCLK    = 1'b0;
        SND_LRCLK   = lr;
        SND_DIN     = tb_prev_din;
        tb_prev_din = d;
        wait_n(4);
        SND_BCLK = 1'b1;
        if (mode < 0) begin
            wait_n(4);
        end else begin
            wait_n(2);
            if (mode == 0) chk("t1_valid_before_push", RX_VALID, 0);
            else RX_READY = 1'b1;
            wait_n(1);
            RX_READY = 1'b0;
            if (mode == 0) begin
                chk("t1_valid_after_push", RX_VALID, 1);
                chk("t1_level", RX_LEVEL, 1);
                chk("t1_data", RX_DATA, 32'h1234ABCD);
            end else begin
                chk("t4_level_full", RX_LEVEL, 16);
                chk("t4_no_over", SND_FIFO_OVER, 0);
                chk("t4_head", RX_DATA, 32'h03020402);
            end
            wait_n(1);
        end
    endtask

    task automatic send_slot(input logic ch, input logic [31:0] v, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            send_bit(ch, v[31-i], (i == 16) ? mode : -1);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int mode);
        send_slot(1'b0, {l, 16'h0000}, 32, -1);
        send_slot(1'b1, {r, 16'h0000}, 32, mode);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        chk(tag, RX_DATA, exp);
        RX_READY = 1'b1;
        wait_n(1);
        RX_READY = 1'b0;
    endtask

    initial begin
        wait_n(3);
        chk("rst_valid", RX_VALID, 0);
        chk("rst_level", RX_LEVEL, 0);
        chk("rst_data", RX_DATA, 0);
        chk("rst_over", SND_FIFO_OVER, 0);
        ARESET = 1'b0;
        RX_EN  = 1'b1;

        // 1: one frame, latency around the push
        send_slot(1'b1, 32'h0, 32, -1);
        send_frame(16'h1234, 16'hABCD, 0);
        pop_check("t1_pop", 32'h1234ABCD);
        chk("t1_empty", RX_LEVEL, 0);

        // 2: reset, then stream starts mid-right slot
        ARESET = 1'b1;
        wait_n(2);
        ARESET = 1'b0;
        send_slot(1'b1, 32'hFFFFFFFF, 20, -1);
        send_frame(16'h1111, 16'h2222, -1);
        chk("t2_level", RX_LEVEL, 1);
        pop_check("t2_first", 32'h11112222);

        // 3: 17 frames with no consumer
        for (int k = 1; k <= 17; k++) begin
            send_frame(16'(16'h0100 + k), 16'(16'h0200 + k), -1);
        end
        chk("t3_level", RX_LEVEL, 16);
        chk("t3_over", SND_FIFO_OVER, 1);
`ifdef SND_RX_DROPCNT_EN
        chk("t3_dropcnt", RX_DROPCNT, 1);
`endif
        for (int k = 1; k <= 16; k++) begin
            pop_check("t3_readback", {16'(16'h0100 + k), 16'(16'h0200 + k)});
        end
        chk("t3_drained", RX_LEVEL, 0);
        OVER_CLR = 1'b1;
        wait_n(1);
        OVER_CLR = 1'b0;
        chk("t3_over_clr", SND_FIFO_OVER, 0);
`ifdef SND_RX_DROPCNT_EN
        chk("t3_dropcnt_clr", RX_DROPCNT, 0);
`endif

        // 4: full FIFO, pop coincides with push
        for (int k = 1; k <= 16; k++) begin
            send_frame(16'(16'h0300 + k), 16'(16'h0400 + k), -1);
        end
        chk("t4_filled", RX_LEVEL, 16);
        send_frame(16'h0311, 16'h0411, 1);
        chk("t4_over_after", SND_FIFO_OVER, 0);
        for (int k = 2; k <= 17; k++) begin
            pop_check("t4_readback", {16'(16'h0300 + k), 16'(16'h0400 + k)});
        end
        chk("t4_drained", RX_LEVEL, 0);

        // 5: 12-bit slots give no frames, 32-bit slots resume
        for (int k = 0; k < 3; k++) begin
            send_slot(1'b0, 32'h55550000, 12, -1);
            send_slot(1'b1, 32'h66660000, 12, -1);
        end
        chk("t5_short_none", RX_LEVEL, 0);
        send_frame(16'h7777, 16'h8888, -1);
        chk("t5_resume_level", RX_LEVEL, 1);
        pop_check("t5_resume", 32'h77778888);

        // 6: reset mid-left word
        send_frame(16'hAAAA, 16'hBBBB, -1);
        chk("t6_pre_level", RX_LEVEL, 1);
        send_slot(1'b0, 32'hEEEE0000, 10, -1);
        ARESET = 1'b1;
        wait_n(1);
        chk("t6_rst_valid", RX_VALID, 0);
        chk("t6_rst_level", RX_LEVEL, 0);
        chk("t6_rst_data", RX_DATA, 0);
        chk("t6_rst_over", SND_FIFO_OVER, 0);
        ARESET = 1'b0;
        send_slot(1'b0, 32'h12345678, 22, -1);
        send_slot(1'b1, 32'h9ABCDEF0, 32, -1);
        send_frame(16'hCCCC, 16'hDDDD, -1);
        chk("t6_level", RX_LEVEL, 1);
        pop_check("t6_first", 32'hCCCCDDDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
